// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// a constant-foldable ceil(log2) helper used to size indices and counters.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Number of bits needed to represent 'value' distinct codes (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// rr_ptr, wrapping past NREQ-1 back to 0. Works for non-power-of-2 NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int cand;

    // Scan from the farthest candidate down to rr_ptr so the nearest set request wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                index = IDX_W'(cand);
                any   = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign onehot[gi] = any && (index == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// The owner keeps the port until its last beat, BURST_MAX accepted beats, or it
// drops req. Acks are gated by wfull so no beat is ever lost at the FIFO.
// Optional feature: define ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int data_size = 8,
    parameter int BURST_MAX = 4
`ifdef ARB_STALL_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*data_size-1:0] req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           ack,
    output logic                      winc,
    output logic [data_size-1:0]      w_data,
    input  logic                      wfull,
    output logic [clog2(NREQ)-1:0]    grant_id,
    output logic                      busy
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt
`endif
);

    localparam int IDX_W  = clog2(NREQ);
    localparam int BCNT_W = clog2(BURST_MAX + 1);
    localparam logic [BCNT_W-1:0] BURST_MAX_CNT = BCNT_W'(BURST_MAX);
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NREQ - 1);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [NREQ-1:0]    owner_oh_reg, owner_oh_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [BCNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [BCNT_W-1:0]  beat_inc;
    logic               owner_req;
    logic               accept;
    logic [NREQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_any;
    logic [data_size-1:0] data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*data_size +: data_size];
        end
    endgenerate

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    assign owner_req = req[owner_reg];
    assign beat_inc  = beat_cnt_reg + 1'b1;

    // Arbiter state: reset aborts any burst immediately, outputs drop with it.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            owner_oh_reg <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            owner_oh_reg <= owner_oh_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state and ack: grant in IDLE, stream beats in OWN, release on last/cap/drop.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        owner_oh_next = owner_oh_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        accept        = 1'b0;
        ack           = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_next    = pick_index;
                    owner_oh_next = pick_onehot;
                    state_next    = ST_OWN;
                end
            end
            ST_OWN: begin
                accept = owner_req & ~wfull;
                ack    = owner_oh_reg & {NREQ{accept}};
                // A stalled owner (wfull) keeps the port; only last/cap/drop rotate it.
                if (!owner_req ||
                    (accept && (req_last[owner_reg] || beat_inc == BURST_MAX_CNT))) begin
                    state_next    = ST_IDLE;
                    beat_cnt_next = '0;
                    rr_ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
                end else if (accept) begin
                    beat_cnt_next = beat_inc;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign winc     = |ack;
    assign w_data   = winc ? data_arr[owner_reg] : '0;
    assign busy     = (state_reg == ST_OWN);
    assign grant_id = owner_reg;

`ifdef ARB_STALL_CNT_EN
    // Count cycles the owner wanted to write but the FIFO was full; saturates.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            stall_cnt <= '0;
        end else if (busy && owner_req && wfull && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Requesters are modelled by beat counters;
// each expected FIFO write is queued when stimulus is set up and popped when winc fires.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  w_data;
    logic        wfull;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arbiter #(
        .NREQ      (4),
        .data_size (8),
        .BURST_MAX (4)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .ack       (ack),
        .winc      (winc),
        .w_data    (w_data),
        .wfull     (wfull),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] cap_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         rem[4];
    logic [7:0] dat[4];
    bit         lastf[4];
    bit         lall[4];
    logic [3:0] ack_seen;
    int         ord[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i]             = (rem[i] > 0);
            req_data[i*8 +: 8] = dat[i];
            req_last[i]        = (rem[i] > 0) && lastf[i] && ((rem[i] == 1) || lall[i]);
        end
    endtask

    // One clock: check writes at negedge, then advance accepted requesters after posedge.
    task automatic tick();
        exp_t        e;
        logic [31:0] oh;
        @(negedge wclk);
        ack_seen = ack;
        chk("winc_vs_ack", {31'd0, winc}, {31'd0, |ack});
        if (winc) begin
            cap_q.push_back(w_data);
            if (sb.size() == 0) begin
                chk("unexpected_beat", sb.size(), 1);
            end else begin
                e  = sb.pop_front();
                oh = 32'd1 << e.id;
                chk("beat_grant_id", {30'd0, grant_id}, e.id);
                chk("beat_w_data", {24'd0, w_data}, {24'd0, e.data});
                chk("beat_ack", {28'd0, ack}, oh);
                $display("beat: id=%0d data=%02h", grant_id, w_data);
            end
        end else begin
            chk("w_data_idle_zero", {24'd0, w_data}, 0);
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack_seen[i]) begin
                rem[i] = rem[i] - 1;
                dat[i] = dat[i] + 8'd1;
            end
        end
        drive();
        #1;
    endtask

    initial begin
        wrst  = 1'b0;
        wfull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; dat[i] = 8'h00; lastf[i] = 1'b0; lall[i] = 1'b0;
        end
        drive();
        tick();
        tick();
        // Reset state
        chk("rst_ack", {28'd0, ack}, 0);
        chk("rst_winc", {31'd0, winc}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);
        chk("rst_wdata", {24'd0, w_data}, 0);
`ifdef ARB_STALL_CNT_EN
        chk("rst_stall", {16'd0, stall_cnt}, 0);
`endif
        wrst = 1'b1;
        tick();

        // 1: reset mid-burst, then regrant of requester 0
        rem[0] = 3; lastf[0] = 1'b1; dat[0] = 8'h00;
        push(0, 8'h00); push(0, 8'h01); push(0, 8'h02);
        drive(); #1;
        chk("t1_idle", {31'd0, busy}, 0);
        tick();
        chk("t1_own", {31'd0, busy}, 1);
        chk("t1_ack1", {28'd0, ack}, 4'b0001);
        tick();
        chk("t1_beat2_pending", {28'd0, ack}, 4'b0001);
        wrst = 1'b0; #1;
        chk("t1_rst_ack", {28'd0, ack}, 0);
        chk("t1_rst_winc", {31'd0, winc}, 0);
        chk("t1_rst_busy", {31'd0, busy}, 0);
        tick();
        wrst = 1'b1; #1;
        chk("t1_post_rst_idle", {31'd0, busy}, 0);
        tick();
        chk("t1_regrant_busy", {31'd0, busy}, 1);
        chk("t1_regrant_id", {30'd0, grant_id}, 0);
        tick();
        tick();
        chk("t1_released", {31'd0, busy}, 0);

        // Clear rr_ptr so the RR order starts from 0
        wrst = 1'b0;
        tick();
        wrst = 1'b1;

        // 2: round robin 0,1,2,3,0 with one idle cycle between grants
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        dat[0] = 8'h00; dat[1] = 8'h10; dat[2] = 8'h20; dat[3] = 8'h30;
        for (int i = 0; i < 4; i++) begin
            lastf[i] = 1'b1; lall[i] = 1'b1;
        end
        push(0, 8'h00); push(1, 8'h10); push(2, 8'h20); push(3, 8'h30); push(0, 8'h01);
        drive(); #1;
        for (int g = 0; g < 5; g++) begin
            chk("t2_gap", {31'd0, busy}, 0);
            tick();
            chk("t2_grant", {30'd0, grant_id}, ord[g]);
            chk("t2_busy", {31'd0, busy}, 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            lall[i] = 1'b0; lastf[i] = 1'b0;
        end

        // 3: burst cap on requester 2, requester 1 waits then is granted
        rem[2] = 6; dat[2] = 8'h40;
        push(2, 8'h40); push(2, 8'h41); push(2, 8'h42); push(2, 8'h43);
        push(1, 8'h50); push(2, 8'h44); push(2, 8'h45);
        drive(); #1;
        chk("t3_idle", {31'd0, busy}, 0);
        tick();
        chk("t3_grant2", {30'd0, grant_id}, 2);
        rem[1] = 1; lastf[1] = 1'b1; dat[1] = 8'h50;
        drive(); #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold", {30'd0, grant_id}, 2);
        end
        tick();
        chk("t3_capped", {31'd0, busy}, 0);
        tick();
        chk("t3_grant1", {30'd0, grant_id}, 1);
        chk("t3_grant1_busy", {31'd0, busy}, 1);
        tick();
        tick();
        tick();
        tick();
        chk("t3_drop_noack", {28'd0, ack}, 0);
        tick();
        chk("t3_done", {31'd0, busy}, 0);

        // 4: wfull stall for 5 OWN cycles, owner held despite a new request
        rem[1] = 2; lastf[1] = 1'b1; dat[1] = 8'h60;
        wfull = 1'b1;
        push(1, 8'h60); push(1, 8'h61); push(3, 8'h70);
        drive(); #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_stall_busy", {31'd0, busy}, 1);
            chk("t4_stall_owner", {30'd0, grant_id}, 1);
            chk("t4_stall_ack", {28'd0, ack}, 0);
            chk("t4_stall_winc", {31'd0, winc}, 0);
            if (k == 0) begin
                rem[3] = 1; lastf[3] = 1'b1; dat[3] = 8'h70;
                drive(); #1;
            end
        end
        tick();
        wfull = 1'b0; #1;
`ifdef ARB_STALL_CNT_EN
        chk("t4_stall_cnt", {16'd0, stall_cnt}, 5);
`endif
        chk("t4_resume_ack", {28'd0, ack}, 4'b0010);
        tick();
        tick();
        chk("t4_idle", {31'd0, busy}, 0);
        tick();
        chk("t4_grant3", {30'd0, grant_id}, 3);
        tick();

        // 5: owner 3 drops req after one beat, rr_ptr wraps, 0 granted
        rem[3] = 1; lastf[3] = 1'b0; dat[3] = 8'h80;
        push(3, 8'h80); push(0, 8'h90);
        drive(); #1;
        tick();
        chk("t5_grant3", {30'd0, grant_id}, 3);
        rem[0] = 1; lastf[0] = 1'b1; dat[0] = 8'h90;
        drive(); #1;
        tick();
        chk("t5_drop_busy", {31'd0, busy}, 1);
        chk("t5_drop_ack", {28'd0, ack}, 0);
        tick();
        chk("t5_release", {31'd0, busy}, 0);
        tick();
        chk("t5_grant0", {30'd0, grant_id}, 0);
        chk("t5_grant0_ack", {28'd0, ack}, 4'b0001);
        tick();

        // 6: data path, requester 1 writes A5
        cap_q.delete();
        rem[1] = 1; lastf[1] = 1'b1; dat[1] = 8'hA5;
        push(1, 8'hA5);
        drive(); #1;
        tick();
        chk("t6_winc", {31'd0, winc}, 1);
        chk("t6_wdata", {24'd0, w_data}, 32'h0000_00A5);
        tick();
        chk("t6_fifo_count", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            chk("t6_readback", {24'd0, cap_q[0]}, 32'h0000_00A5);
        end
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
